// File: rtl/sync_fifo_wr_arbiter.sv
// Round-robin write-port arbiter in front of a single sync FIFO.
// Each grant may stream up to MAX_BURST words; writes are held off while the FIFO is full.
module sync_fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            ack_o,
    input  logic                          fifo_full_i,
    output logic                          fifo_write_o,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data_o,
    output logic                          busy_o
);

    // state | meaning
    // IDLE  | no owner, gnt_o=0, waiting for any request
    // BURST | one producer owns the write port, burst_cnt counts its accepted words

    localparam int RR_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BURST} state_t;

    typedef struct packed {
        logic            found;
        logic [RR_W-1:0] idx;
    } pick_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [RR_W-1:0]      owner_q, owner_d;
    logic [RR_W-1:0]      rr_q, rr_d;
    logic [CNT_W-1:0]     burst_cnt_q, burst_cnt_d;
    logic                 busy_q;

    logic [RR_W-1:0]      next_ptr;
    logic [NUM_REQ-1:0]   owner_mask;
    pick_t                pick_idle, pick_rel;
    logic                 owner_req;
    logic                 last_word;

    logic [DATA_WIDTH-1:0] masked_data [NUM_REQ];
    logic [DATA_WIDTH-1:0] data_chain  [NUM_REQ+1];

    // First set bit of mask searching from start upwards, wrapping at NUM_REQ.
    function automatic pick_t pick(input logic [RR_W-1:0] start, input logic [NUM_REQ-1:0] mask);
        pick_t           res;
        logic [RR_W-1:0] pos;
        res = '0;
        pos = start;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!res.found && mask[pos]) begin
                res.found = 1'b1;
                res.idx   = pos;
            end
            pos = (pos == RR_W'(NUM_REQ - 1)) ? '0 : pos + 1'b1;
        end
        return res;
    endfunction

    assign gnt_o  = gnt_q;
    assign busy_o = busy_q;
    assign ack_o  = gnt_q & req_i & {NUM_REQ{~fifo_full_i}};
    assign fifo_write_o = |ack_o;

    // AND-OR mux keeps the write data at zero when nobody holds the grant.
    assign data_chain[0] = '0;
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_data_mux
        assign masked_data[k]  = gnt_q[k] ? data_i[k*DATA_WIDTH +: DATA_WIDTH] : '0;
        assign data_chain[k+1] = data_chain[k] | masked_data[k];
    end
    assign fifo_wr_data_o = data_chain[NUM_REQ];

    assign next_ptr   = (owner_q == RR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign owner_mask = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
    assign owner_req  = req_i[owner_q];
    assign last_word  = fifo_write_o && (burst_cnt_q == CNT_W'(MAX_BURST - 1));
    assign pick_idle  = pick(rr_q, req_i);
    assign pick_rel   = pick(next_ptr, req_i & ~owner_mask);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        burst_cnt_d = burst_cnt_q;
        if (state_q == IDLE) begin
            if (pick_idle.found) begin
                state_d     = BURST;
                owner_d     = pick_idle.idx;
                gnt_d       = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idle.idx;
                burst_cnt_d = '0;
            end
        end else begin
            if (!owner_req || last_word) begin
                rr_d        = next_ptr;
                burst_cnt_d = '0;
                if (pick_rel.found) begin
                    owner_d = pick_rel.idx;
                    gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_rel.idx;
                end else if (!owner_req) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
                // otherwise a sole producer that hit its burst limit keeps the port
            end else if (fifo_write_o) begin
                burst_cnt_d = burst_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            owner_q     <= '0;
            rr_q        <= '0;
            burst_cnt_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            burst_cnt_q <= burst_cnt_d;
            busy_q      <= (state_d == BURST);
        end
    end

    a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(gnt_o));
    a_ack_onehot0: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(ack_o));
    a_no_wr_full:  assert property (@(posedge clk_i) disable iff (rst_i) !(fifo_write_o && fifo_full_i));
    a_cnt_range:   assert property (@(posedge clk_i) disable iff (rst_i) burst_cnt_q < CNT_W'(MAX_BURST));

endmodule

// File: tb/tb_sync_fifo_wr_arbiter.sv
// Bench for sync_fifo_wr_arbiter: MAX_BURST=4 and MAX_BURST=1 instances on shared stimulus,
// checked every cycle against a queue/integer model plus literal expectations per scenario.
module tb_sync_fifo_wr_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [3:0]   req = 4'b0;
    logic [127:0] data = '0;
    logic         full = 1'b0;

    logic [3:0]   gnt_a, ack_a, gnt_b, ack_b;
    logic         wr_a, wr_b, busy_a, busy_b;
    logic [31:0]  wd_a, wd_b;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    int m_owner [2];
    int m_cnt   [2];
    int m_rr    [2];
    int maxb    [2];
    int wcnt    [4];

    int          lp_a[$], lc_a[$], lp_b[$], lc_b[$];
    logic [31:0] ld_a[$];

    sync_fifo_wr_arbiter #(.DATA_WIDTH(32), .NUM_REQ(4), .MAX_BURST(4)) dut_a (
        .clk_i(clk), .rst_i(rst), .req_i(req), .data_i(data), .gnt_o(gnt_a), .ack_o(ack_a),
        .fifo_full_i(full), .fifo_write_o(wr_a), .fifo_wr_data_o(wd_a), .busy_o(busy_a));

    sync_fifo_wr_arbiter #(.DATA_WIDTH(32), .NUM_REQ(4), .MAX_BURST(1)) dut_b (
        .clk_i(clk), .rst_i(rst), .req_i(req), .data_i(data), .gnt_o(gnt_b), .ack_o(ack_b),
        .fifo_full_i(full), .fifo_write_o(wr_b), .fifo_wr_data_o(wd_b), .busy_o(busy_b));

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick(input int start, input logic [3:0] m);
        for (int i = 0; i < 4; i++)
            if (m[2'((start + i) % 4)]) return (start + i) % 4;
        return -1;
    endfunction

    // Expected outputs follow from the current owner; then apply the grant/release rules.
    task automatic model_cycle(input int d, input logic [3:0] g, input logic [3:0] a,
                               input logic w, input logic [31:0] wd, input logic b);
        int          o, n;
        logic [3:0]  eg, ea, mk;
        logic [31:0] ed;
        bit          acked;
        if (rst) begin
            m_owner[d] = -1; m_cnt[d] = 0; m_rr[d] = 0;
        end
        o = m_owner[d];
        eg = 4'b0; ed = '0; acked = 1'b0;
        if (o >= 0) begin
            eg = 4'b0001 << o;
            ed = 32'(data >> (32 * o));
            acked = req[2'(o)] && !full;
        end
        ea = acked ? eg : 4'b0;
        chk($sformatf("gnt%0d", d),  32'(g),  32'(eg));
        chk($sformatf("ack%0d", d),  32'(a),  32'(ea));
        chk($sformatf("wr%0d", d),   32'(w),  32'(acked));
        chk($sformatf("wdat%0d", d), wd,      ed);
        chk($sformatf("busy%0d", d), 32'(b),  32'(o >= 0));
        if (acked) begin
            if (d == 0) begin lp_a.push_back(o); lc_a.push_back(cyc); ld_a.push_back(ed); end
            else        begin lp_b.push_back(o); lc_b.push_back(cyc); end
        end
        if (rst) return;
        if (o < 0) begin
            n = pick(m_rr[d], req);
            if (n >= 0) begin m_owner[d] = n; m_cnt[d] = 0; end
        end else if (!req[2'(o)] || (acked && m_cnt[d] == maxb[d] - 1)) begin
            m_rr[d] = (o + 1) % 4;
            mk = req & ~(4'b0001 << o);
            n = pick(m_rr[d], mk);
            m_cnt[d] = 0;
            if (n >= 0) m_owner[d] = n;
            else if (!req[2'(o)]) m_owner[d] = -1;
        end else if (acked) begin
            m_cnt[d]++;
        end
    endtask

    // Compare process; also plays the producers, advancing each word counter on its ack.
    initial begin
        logic [3:0] ackd;
        maxb[0] = 4; maxb[1] = 1;
        for (int d = 0; d < 2; d++) begin m_owner[d] = -1; m_cnt[d] = 0; m_rr[d] = 0; end
        for (int k = 0; k < 4; k++) wcnt[k] = 0;
        forever begin
            @(negedge clk);
            cyc++;
            model_cycle(0, gnt_a, ack_a, wr_a, wd_a, busy_a);
            model_cycle(1, gnt_b, ack_b, wr_b, wd_b, busy_b);
            ackd = ack_a;
            if (rst) for (int k = 0; k < 4; k++) wcnt[k] = 0;
            @(posedge clk);
            #1;
            for (int k = 0; k < 4; k++) begin
                if (!rst && ackd[2'(k)]) wcnt[k]++;
                data[k*32 +: 32] = {16'(k), 16'(wcnt[k])};
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0;
        full = 1'b0;
        tick(2);
        lp_a.delete(); lc_a.delete(); ld_a.delete(); lp_b.delete(); lc_b.delete();
        rst = 1'b0;
    endtask

    initial begin
        int c0;
        int exp_p4 [10];
        int exp_p5 [6];
        exp_p4 = '{1, 1, 3, 3, 3, 3, 1, 1, 1, 1};
        exp_p5 = '{0, 0, 0, 0, 1, 1};
        tick(2);

        // reset mid-burst
        do_reset();
        req = 4'b1111;
        tick(3);
        chk("pre_rst_gnt", 32'(gnt_a), 32'h1);
        rst = 1'b1;
        #1;
        chk("rst_gnt",  32'(gnt_a),  32'h0);
        chk("rst_ack",  32'(ack_a),  32'h0);
        chk("rst_wr",   32'(wr_a),   32'h0);
        chk("rst_busy", 32'(busy_a), 32'h0);
        #1;
        req = 4'b0001;
        tick(1);
        rst = 1'b0;
        tick(1);
        chk("post_rst_gnt", 32'(gnt_a), 32'h1);
        req = 4'b0;
        tick(2);

        // sole producer 2: back-to-back writes across re-grants
        do_reset();
        c0 = cyc;
        req = 4'b0100;
        tick(12);
        req = 4'b0;
        tick(2);
        chk("sole_count", 32'(lp_a.size()), 32'd11);
        if (lc_a.size() > 0) chk("sole_first_cyc", 32'(lc_a[0] - c0), 32'd2);
        for (int i = 0; i < lp_a.size() && i < 11; i++) begin
            chk("sole_prod", 32'(lp_a[i]), 32'd2);
            chk("sole_data", ld_a[i], {16'd2, 16'(i)});
            chk("sole_gap", 32'(lc_a[i] - lc_a[0]), 32'(i));
        end

        // all four requesting: 4 words each, in producer order
        do_reset();
        req = 4'b1111;
        tick(18);
        req = 4'b0;
        tick(2);
        chk("rr_count", 32'(lp_a.size()), 32'd17);
        for (int i = 0; i < lp_a.size() && i < 17; i++) begin
            if (i < 16) begin
                chk("rr_prod", 32'(lp_a[i]), 32'(i / 4));
                chk("rr_data", ld_a[i], {16'(i / 4), 16'(i % 4)});
            end else begin
                chk("rr_wrap_prod", 32'(lp_a[i]), 32'd0);
                chk("rr_wrap_data", ld_a[i], {16'd0, 16'd4});
            end
        end

        // early release by owner 1 while 3 is waiting
        do_reset();
        req = 4'b1010;
        tick(3);
        req = 4'b1000;
        tick(1);
        chk("early_gnt", 32'(gnt_a), 32'h8);
        req = 4'b1010;
        tick(8);
        req = 4'b0;
        tick(2);
        chk("early_count", 32'(lp_a.size()), 32'd10);
        for (int i = 0; i < lp_a.size() && i < 10; i++)
            chk("early_prod", 32'(lp_a[i]), 32'(exp_p4[i]));

        // FIFO full for 5 cycles after owner 0 has written 2 words
        do_reset();
        req = 4'b0011;
        tick(3);
        full = 1'b1;
        tick(2);
        chk("stall_gnt", 32'(gnt_a), 32'h1);
        chk("stall_wr",  32'(wr_a),  32'h0);
        tick(3);
        chk("stall_gnt_end", 32'(gnt_a), 32'h1);
        full = 1'b0;
        tick(4);
        req = 4'b0;
        tick(2);
        chk("stall_count", 32'(lp_a.size()), 32'd6);
        for (int i = 0; i < lp_a.size() && i < 6; i++)
            chk("stall_prod", 32'(lp_a[i]), 32'(exp_p5[i]));
        if (lc_a.size() >= 3) chk("stall_gap", 32'(lc_a[2] - lc_a[1]), 32'd6);

        // MAX_BURST=1 instance: word-interleaved 1,3,1,3 with no bubbles
        do_reset();
        req = 4'b1010;
        tick(7);
        req = 4'b0;
        tick(2);
        chk("mb1_count", 32'(lp_b.size()), 32'd6);
        for (int i = 0; i < lp_b.size() && i < 6; i++) begin
            chk("mb1_prod", 32'(lp_b[i]), (i % 2 == 0) ? 32'd1 : 32'd3);
            chk("mb1_gap", 32'(lc_b[i] - lc_b[0]), 32'(i));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
